cpu_noc_tx_arbiter: RTL and testbench

CPU_NOC_TX_ARBITER -- requirements
Module: cpu_noc_tx_arbiter

---
 rtl/cpu_noc_tx_arbiter.sv | 100 ++++++++++
 tb/tb_cpu_noc_tx_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_noc_tx_arbiter.sv
// Round-robin arbiter feeding CPU packets, one at a time, to the NoC flitizer.
// The grant is held from acceptance until the flitizer reports the tail flit.
module cpu_noc_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PKT_WIDTH = 64,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*PKT_WIDTH-1:0] req_packet,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         flit_packet_valid,
    output logic [PKT_WIDTH-1:0]         flit_packet,
    input  logic                         flit_packet_ready,
    input  logic                         flit_done,
    output logic [IDW-1:0]               grant_id,
    output logic                         busy,
    output logic [15:0]                  pkt_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           found;
    logic           accept;
    logic           complete;

    // First valid requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        accept    = 1'b0;
        complete  = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    req_ready[win] = 1'b1;
                    accept         = 1'b1;
                    state_nx       = ISSUE;
                end
            end
            ISSUE: begin
                if (flit_packet_ready) state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (flit_done) begin
                    complete = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            flit_packet <= '0;
            pkt_count   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                flit_packet <= req_packet[int'(win)*PKT_WIDTH +: PKT_WIDTH];
                grant_id    <= win;
            end
            if (complete) begin
                rr_ptr    <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

    assign flit_packet_valid = (state == ISSUE);
    assign busy              = (state != IDLE);

endmodule

// File: tb/tb_cpu_noc_tx_arbiter.sv
// Scoreboard bench for cpu_noc_tx_arbiter: grants are queued when issued
// and popped by a monitor at every packet handshake with the flitizer.
module tb_cpu_noc_tx_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [255:0] req_packet;
    logic [3:0]   req_ready;
    logic         flit_packet_valid;
    logic [63:0]  flit_packet;
    logic         flit_packet_ready;
    logic         flit_done;
    logic [1:0]   grant_id;
    logic         busy;
    logic [15:0]  pkt_count;

    typedef struct {
        logic [1:0]  gid;
        logic [63:0] pkt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    cpu_noc_tx_arbiter #(.NUM_REQ(4), .PKT_WIDTH(64)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_packet        (req_packet),
        .req_ready         (req_ready),
        .flit_packet_valid (flit_packet_valid),
        .flit_packet       (flit_packet),
        .flit_packet_ready (flit_packet_ready),
        .flit_done         (flit_done),
        .grant_id          (grant_id),
        .busy              (busy),
        .pkt_count         (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted packet must match the oldest queued grant.
    always @(negedge clk) begin
        if (rst_n && flit_packet_valid && flit_packet_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_pkt: got %0h expected none",
                         flit_packet);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pkt", flit_packet, e.pkt);
                chk("sb_gid", {62'd0, grant_id}, {62'd0, e.gid});
            end
        end
    end

    // Called at posedge+1 in IDLE with req_valid already driven.
    task automatic run_pkt(input int gid, input int done_delay);
        sb.push_back('{gid: 2'(gid), pkt: req_packet[gid*64 +: 64]});
        @(negedge clk);
        chk("rr_ready", {60'd0, req_ready}, 64'(1) << gid);
        tick();
        flit_packet_ready = 1'b1;
        tick();
        flit_packet_ready = 1'b0;
        repeat (done_delay - 1) tick();
        flit_done = 1'b1;
        tick();
        flit_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n             = 1'b0;
        req_valid         = '0;
        req_packet        = '0;
        flit_packet_ready = 1'b0;
        flit_done         = 1'b0;
        repeat (2) tick();
        chk("rst_ready", {60'd0, req_ready}, 64'd0);
        chk("rst_valid", {63'd0, flit_packet_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_cnt", {48'd0, pkt_count}, 64'd0);
        chk("rst_gid", {62'd0, grant_id}, 64'd0);
        chk("rst_pkt", flit_packet, 64'd0);
        rst_n = 1'b1;
        tick();

        // Single requester 2, then a stalled flitizer.
        req_packet[2*64 +: 64] = 64'hA5;
        req_valid = 4'b0100;
        sb.push_back('{gid: 2'd2, pkt: 64'hA5});
        @(negedge clk);
        chk("t29_ready", {60'd0, req_ready}, 64'b0100);
        tick();
        req_valid = '0;
        req_packet[2*64 +: 64] = 64'hFF;
        @(negedge clk);
        chk("t29_valid", {63'd0, flit_packet_valid}, 64'd1);
        chk("t29_gid", {62'd0, grant_id}, 64'd2);
        chk("t29_busy", {63'd0, busy}, 64'd1);
        chk("t29_pkt", flit_packet, 64'hA5);
        req_valid = 4'b1111;
        repeat (6) begin
            tick();
            @(negedge clk);
            chk("t31_valid", {63'd0, flit_packet_valid}, 64'd1);
            chk("t31_pkt", flit_packet, 64'hA5);
            chk("t31_ready", {60'd0, req_ready}, 64'd0);
        end
        tick();
        req_valid         = '0;
        flit_packet_ready = 1'b1;
        flit_done         = 1'b1;
        tick();
        flit_packet_ready = 1'b0;
        flit_done         = 1'b0;
        @(negedge clk);
        chk("t32_busy", {63'd0, busy}, 64'd1);
        chk("t32_valid", {63'd0, flit_packet_valid}, 64'd0);
        chk("t32_cnt", {48'd0, pkt_count}, 64'd0);
        tick();
        flit_done = 1'b1;
        tick();
        flit_done = 1'b0;
        @(negedge clk);
        chk("t32_cnt2", {48'd0, pkt_count}, 64'd1);
        chk("t32_idle", {63'd0, busy}, 64'd0);

        // rr_ptr is 3 now: requesters 0,1 valid -> wrap to 0.
        tick();
        req_packet[0 +: 64]  = 64'h0F0F;
        req_packet[64 +: 64] = 64'h1F1F;
        req_valid = 4'b0011;
        run_pkt(0, 2);
        req_valid = '0;

        // All four valid from reset: order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 4; i++) req_packet[i*64 +: 64] = 64'h1000 + 64'(i);
        req_valid = 4'b1111;
        run_pkt(0, 3);
        run_pkt(1, 3);
        run_pkt(2, 3);
        run_pkt(3, 3);
        run_pkt(0, 3);
        req_valid = '0;
        @(negedge clk);
        chk("t30_cnt", {48'd0, pkt_count}, 64'd5);

        // Reset while WAIT_DONE with grant 3.
        tick();
        req_packet[3*64 +: 64] = 64'hC3;
        req_valid = 4'b1000;
        sb.push_back('{gid: 2'd3, pkt: 64'hC3});
        @(negedge clk);
        chk("t33_ready", {60'd0, req_ready}, 64'b1000);
        tick();
        req_valid         = '0;
        flit_packet_ready = 1'b1;
        tick();
        flit_packet_ready = 1'b0;
        @(negedge clk);
        chk("t33_gid", {62'd0, grant_id}, 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t33_rgid", {62'd0, grant_id}, 64'd0);
        chk("t33_rbusy", {63'd0, busy}, 64'd0);
        chk("t33_rvalid", {63'd0, flit_packet_valid}, 64'd0);
        chk("t33_rpkt", flit_packet, 64'd0);
        chk("t33_rcnt", {48'd0, pkt_count}, 64'd0);
        #1;
        rst_n = 1'b1;
        tick();
        req_valid = 4'b1010;
        run_pkt(1, 1);
        req_valid = '0;

        // Counter wrap from 16'hFFFF.
        tick();
        req_valid = 4'b0001;
        sb.push_back('{gid: 2'd0, pkt: req_packet[0 +: 64]});
        tick();
        req_valid         = '0;
        flit_packet_ready = 1'b1;
        tick();
        flit_packet_ready = 1'b0;
        force dut.pkt_count = 16'hFFFF;
        #1;
        release dut.pkt_count;
        flit_done = 1'b1;
        tick();
        flit_done = 1'b0;
        @(negedge clk);
        chk("t34_wrap", {48'd0, pkt_count}, 64'd0);

        repeat (3) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
